// File: rtl/dense_pkg.sv
// Shared state encoding and output saturation helper for the dense layer.
package dense_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    // ReLU followed by clamp to the largest positive value of a 'bits'-wide signed word.
    // The caller sign-extends its accumulator to 64 bits and truncates the result.
    function automatic logic signed [63:0] relu_sat(input logic signed [63:0] acc,
                                                    input int                 bits);
        logic signed [63:0] max_v;
        max_v = (64'sd1 <<< (bits - 1)) - 64'sd1;
        if (acc < 64'sd0) begin
            return '0;
        end else if (acc > max_v) begin
            return max_v;
        end else begin
            return acc;
        end
    endfunction

endpackage

// File: rtl/dense_layer_if.sv
// Streaming input/output bus of the dense layer, plus its static weight table.
interface dense_layer_if #(
    parameter int BitSize      = 4,
    parameter int InputSize    = 4,
    parameter int NumOfBeats   = 4,
    parameter int NumOfNeurons = 2
);
    logic                                                    in_valid;
    logic                                                    in_ready;
    logic [InputSize-1:0][BitSize-1:0]                       in_data;
    logic [NumOfNeurons-1:0][NumOfBeats*InputSize-1:0][BitSize-1:0] weights;
    logic                                                    out_valid;
    logic                                                    out_ready;
    logic [NumOfNeurons-1:0][BitSize-1:0]                    out_data;

    modport slave (
        input  in_valid, in_data, weights, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, weights, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/dense_neuron_mac.sv
// One neuron: dot product of the current beat with its weight slice, accumulated over a sample.
module dense_neuron_mac #(
    parameter int BitSize    = 4,
    parameter int InputSize  = 4,
    parameter int NumOfBeats = 4,
    parameter int AccWidth   = 2*BitSize + $clog2(InputSize*NumOfBeats) + 1,
    parameter int CntW       = 2
) (
    input  logic                                              clk,
    input  logic                                              res_n,
    input  logic                                              clr_i,
    input  logic                                              en_i,
    input  logic [CntW-1:0]                                   beat_i,
    input  logic [InputSize-1:0][BitSize-1:0]                 in_data_i,
    input  logic [NumOfBeats-1:0][InputSize-1:0][BitSize-1:0] weights_i,
    output logic signed [AccWidth-1:0]                        acc_next_o
);
    logic signed [AccWidth-1:0]  acc_q;
    logic signed [AccWidth-1:0]  acc_d;
    logic signed [AccWidth-1:0]  dot;
    logic signed [2*BitSize-1:0] prod;

    // Operands are widened before the multiply so the full signed product is kept.
    always_comb begin
        dot  = '0;
        prod = '0;
        for (int k = 0; k < InputSize; k++) begin
            prod = (2*BitSize)'($signed(in_data_i[k])) *
                   (2*BitSize)'($signed(weights_i[beat_i][k]));
            dot  = dot + AccWidth'(prod);
        end
    end

    assign acc_next_o = acc_q + dot;

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_next_o;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
endmodule

// File: rtl/dense_layer.sv
// Fully connected layer: accumulates NumOfBeats input beats per sample, emits ReLU-saturated outputs.
module dense_layer
    import dense_pkg::*;
#(
    parameter int BitSize      = 4,
    parameter int InputSize    = 4,
    parameter int NumOfBeats   = 4,
    parameter int NumOfNeurons = 2,
    parameter int AccWidth     = 2*BitSize + $clog2(InputSize*NumOfBeats) + 1
) (
    input logic          clk,
    input logic          res_n,
    dense_layer_if.slave bus
);
    localparam int              CntW     = (NumOfBeats > 1) ? $clog2(NumOfBeats) : 1;
    localparam logic [CntW-1:0] LastBeat = CntW'(NumOfBeats - 1);

    state_t                               state_q, state_d;
    logic [CntW-1:0]                      cnt_q, cnt_d;
    logic [NumOfNeurons-1:0][BitSize-1:0] out_q, out_d;
    logic                                 in_rdy;
    logic                                 accept;
    logic                                 last;
    logic                                 clr;
    logic signed [AccWidth-1:0]           acc_next [NumOfNeurons];

    assign in_rdy        = (state_q != DONE);
    assign accept        = bus.in_valid && in_rdy;
    assign last          = (cnt_q == LastBeat);
    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = out_q;

    // The counter holds at the last beat through DONE and is cleared on the output handshake.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr     = 1'b0;
        unique case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    if (last) begin
                        state_d = DONE;
                    end else begin
                        state_d = ACCUM;
                        cnt_d   = cnt_q + CntW'(1);
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    clr     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs capture the accumulator value that includes the final beat.
    always_comb begin
        out_d = out_q;
        if (accept && last) begin
            for (int n = 0; n < NumOfNeurons; n++) begin
                out_d[n] = BitSize'(relu_sat(64'(acc_next[n]), BitSize));
            end
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    for (genvar n = 0; n < NumOfNeurons; n++) begin : g_neuron
        dense_neuron_mac #(
            .BitSize   (BitSize),
            .InputSize (InputSize),
            .NumOfBeats(NumOfBeats),
            .AccWidth  (AccWidth),
            .CntW      (CntW)
        ) u_mac (
            .clk       (clk),
            .res_n     (res_n),
            .clr_i     (clr),
            .en_i      (accept),
            .beat_i    (cnt_q),
            .in_data_i (bus.in_data),
            .weights_i (bus.weights[n]),
            .acc_next_o(acc_next[n])
        );
    end
endmodule

// File: tb/tb_dense_layer.sv
// Randomised and directed checks of dense_layer against a plain-integer reference model.
module tb_dense_layer;
    localparam int BS = 4;
    localparam int IS = 4;
    localparam int NB = 4;
    localparam int NN = 2;

    logic clk = 1'b0;
    logic res_n;

    int n_tests = 0;
    int n_fail  = 0;
    int wt    [NN][NB*IS];
    int beats [NB][IS];

    dense_layer_if #(.BitSize(BS), .InputSize(IS), .NumOfBeats(NB), .NumOfNeurons(NN)) bus ();

    dense_layer #(
        .BitSize     (BS),
        .InputSize   (IS),
        .NumOfBeats  (NB),
        .NumOfNeurons(NN)
    ) dut (
        .clk  (clk),
        .res_n(res_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Whole-sample dot product in plain integers, then ReLU and clamp to 2^(BS-1)-1.
    function automatic int model_out(input int n);
        int acc = 0;
        for (int b = 0; b < NB; b++)
            for (int k = 0; k < IS; k++)
                acc += beats[b][k] * wt[n][b*IS + k];
        if (acc < 0) return 0;
        if (acc > (1 << (BS-1)) - 1) return (1 << (BS-1)) - 1;
        return acc;
    endfunction

    task automatic apply_weights();
        for (int n = 0; n < NN; n++)
            for (int i = 0; i < NB*IS; i++)
                bus.weights[n][i] = BS'(wt[n][i]);
    endtask

    task automatic drive_beat(input int b);
        for (int k = 0; k < IS; k++)
            bus.in_data[k] = BS'(beats[b][k]);
    endtask

    task automatic run_sample(input int gmin, input int gmax, input int hold, input string tag);
        int exp_v [NN];
        int gap;
        for (int n = 0; n < NN; n++) exp_v[n] = model_out(n);
        for (int b = 0; b < NB; b++) begin
            @(negedge clk);
            bus.in_valid  = 1'b1;
            drive_beat(b);
            bus.out_ready = 1'($urandom_range(1, 0));
            if (b == NB-1) chk({tag, "_early_valid"}, int'(bus.out_valid), 0);
            @(posedge clk);
            if (b < NB-1) begin
                gap = int'($urandom_range(gmax, gmin));
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    bus.in_valid  = 1'b0;
                    bus.in_data   = (IS*BS)'($urandom);
                    bus.out_ready = 1'($urandom_range(1, 0));
                    @(posedge clk);
                end
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk({tag, "_valid"}, int'(bus.out_valid), 1);
        chk({tag, "_ready_low"}, int'(bus.in_ready), 0);
        for (int n = 0; n < NN; n++) chk($sformatf("%s_data%0d", tag, n), int'(bus.out_data[n]), exp_v[n]);
        for (int h = 0; h < hold; h++) begin
            bus.out_ready = 1'b0;
            bus.in_valid  = 1'b1;
            bus.in_data   = (IS*BS)'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_hold_valid"}, int'(bus.out_valid), 1);
            chk({tag, "_hold_ready"}, int'(bus.in_ready), 0);
            for (int n = 0; n < NN; n++) chk($sformatf("%s_hold_data%0d", tag, n), int'(bus.out_data[n]), exp_v[n]);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_post_valid"}, int'(bus.out_valid), 0);
        chk({tag, "_post_ready"}, int'(bus.in_ready), 1);
        for (int n = 0; n < NN; n++) chk($sformatf("%s_keep_data%0d", tag, n), int'(bus.out_data[n]), exp_v[n]);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        res_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_data   = '0;
        bus.weights   = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_data", int'(bus.out_data), 0);
        res_n = 1'b1;

        // +1 / -1 weights with beats 1..4: sums of +40 and -40 saturate to 7 and 0.
        for (int i = 0; i < NB*IS; i++) begin wt[0][i] = 1; wt[1][i] = -1; end
        for (int b = 0; b < NB; b++) for (int k = 0; k < IS; k++) beats[b][k] = b + 1;
        apply_weights();
        run_sample(0, 0, 0, "b2b");
        run_sample(1, 1, 0, "gap1");
        run_sample(0, 0, 3, "backpr");

        for (int i = 0; i < NB*IS; i++) begin wt[0][i] = 1; wt[1][i] = 0; end
        for (int b = 0; b < NB; b++) for (int k = 0; k < IS; k++) beats[b][k] = (b == 0) ? 1 : 0;
        apply_weights();
        run_sample(0, 0, 0, "one_beat");

        for (int s = 0; s < 20; s++) begin
            for (int n = 0; n < NN; n++)
                for (int i = 0; i < NB*IS; i++) wt[n][i] = int'($urandom_range(15, 0)) - 8;
            for (int b = 0; b < NB; b++)
                for (int k = 0; k < IS; k++) beats[b][k] = int'($urandom_range(15, 0)) - 8;
            apply_weights();
            run_sample(0, 2, int'($urandom_range(3, 0)), $sformatf("rnd%0d", s));
        end

        // Two beats, then reset: the partial sum must not leak into the next sample.
        for (int i = 0; i < NB*IS; i++) begin wt[0][i] = 1; wt[1][i] = int'($urandom_range(15, 0)) - 8; end
        apply_weights();
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = (IS*BS)'($urandom);
            @(posedge clk);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        res_n        = 1'b0;
        #1;
        chk("midrst_out_valid", int'(bus.out_valid), 0);
        chk("midrst_in_ready", int'(bus.in_ready), 1);
        chk("midrst_out_data", int'(bus.out_data), 0);
        @(negedge clk);
        res_n = 1'b1;
        for (int b = 0; b < NB; b++) for (int k = 0; k < IS; k++) beats[b][k] = 1;
        run_sample(0, 1, 1, "after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dense_layer.md
DENSE_LAYER -- requirements
Module: dense_layer

Interface
REQ-001 Parameter BitSize, 4, width of every data and weight word (signed two's complement).
REQ-002 Parameter InputSize, 4, words per input beat (equals upstream flattening-layer ImageSize).
REQ-003 Parameter NumOfBeats, 4, input beats per sample (equals upstream NumOfImages).
REQ-004 Parameter NumOfNeurons, 2, output neurons.
REQ-005 Parameter AccWidth, 2*BitSize+$clog2(InputSize*NumOfBeats)+1, accumulator width.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 res_n  input  1  asynchronous, active-low reset.
REQ-008 in_valid  input  1  in_data holds one flattened beat.
REQ-009 in_data  input  [InputSize][BitSize]  flattened beat from the upstream flattening layer.
REQ-010 in_ready  output  1  block accepts a beat this cycle.
REQ-011 weights  input  [NumOfNeurons][NumOfBeats*InputSize][BitSize]  static weights, stable while not idle.
REQ-012 out_valid  output  1  out_data holds a finished sample.
REQ-013 out_data  output  [NumOfNeurons][BitSize]  ReLU-saturated neuron outputs.
REQ-014 out_ready  input  1  downstream accepts out_data.

Function
REQ-015 A beat SHALL be accepted only when in_valid and in_ready are both 1 on a rising edge; in_valid-low cycles SHALL be ignored and not counted.
REQ-016 The FSM SHALL have states IDLE, ACCUM and DONE.
REQ-017 IDLE: accumulators zero, beat counter 0; an accepted beat moves to ACCUM, or directly to DONE when NumOfBeats is 1.
REQ-018 ACCUM: each accepted beat increments the beat counter; acceptance of beat NumOfBeats-1 moves to DONE.
REQ-019 DONE: out_valid SHALL be 1 and in_ready 0; on out_ready=1 move to IDLE and clear accumulators and counter in the same edge.
REQ-020 in_ready SHALL be 1 in IDLE and ACCUM, 0 in DONE; combinational from state only.
REQ-021 Per accepted beat b, neuron n SHALL add sum over k of in_data[k]*weights[n][b*InputSize+k], signed, full precision into AccWidth.
REQ-022 out_data[n] SHALL be registered on the final-beat edge: 0 if acc<0, 2^(BitSize-1)-1 if acc exceeds it, else acc[BitSize-1:0].
REQ-023 Latency: out_valid SHALL rise the cycle after the final beat is accepted.
REQ-024 out_data and out_valid SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 out_data SHALL keep its last value after the handshake until the next sample completes.
REQ-026 out_ready while not in DONE SHALL have no effect.

Reset
REQ-027 res_n=0 SHALL immediately force state IDLE, beat counter 0, all accumulators 0, out_valid 0, out_data 0, in_ready 1 after release.
REQ-028 Reset mid-sample SHALL discard partial accumulation; the next NumOfBeats accepted beats form a fresh sample.

Structure
REQ-029 Package dense_pkg SHALL hold the state enum (IDLE, ACCUM, DONE) and the ReLU-saturate function (parameterised by widths).
REQ-030 One sub-module, dense_neuron_mac, SHALL implement one neuron's per-beat dot product and accumulator, instantiated NumOfNeurons times; the top holds FSM, counter and output registers.

Verification (BitSize=4, InputSize=4, NumOfBeats=4, NumOfNeurons=2)
REQ-031 Weights n0 all +1, n1 all -1; beats all-1, all-2, all-3, all-4 back-to-back, out_ready=1 -> acc n0=+40, n1=-40; out_data={0,7} with out_valid high one cycle, one cycle after beat 4.
REQ-032 Weights n0 all +1, n1 all +0; beats all-1, then three all-0 -> out_data n0=4, n1=0.
REQ-033 Same as REQ-031 with one in_valid-low cycle between every beat -> identical result, out_valid one cycle after the fourth valid beat.
REQ-034 out_ready held 0 for 3 cycles after completion -> out_valid and out_data stable, in_ready 0, beats presented are not accepted; out_ready=1 -> IDLE next cycle.
REQ-035 res_n pulsed low after 2 accepted beats, then 4 beats of all-1 with n0 weights +1 -> out_data n0=7 (acc 16 saturated), no contamination from pre-reset beats.
